// File: rtl/accelerator_vector_write_gate_pkg.sv
// rtl/accelerator_vector_write_gate_pkg.sv - shared state encoding and constants for the vector write gate
package accelerator_vector_write_gate_pkg;

   // Controller states of the vector sequencer
   typedef enum logic [1:0] {
      STARTER_STATE = 2'd0,
      INPUT_STATE   = 2'd1,
      ENDER_STATE   = 2'd2
   } state_t;

   localparam logic [63:0] ZERO_CONTROL = 64'd0;
   localparam logic [63:0] ONE_CONTROL  = 64'd1;
   localparam logic [63:0] ZERO_DATA    = 64'd0;

endpackage

// File: rtl/accelerator_scalar_logistic_function.sv
// rtl/accelerator_scalar_logistic_function.sv - two-stage piecewise-linear scalar logistic unit
module accelerator_scalar_logistic_function
   import accelerator_vector_write_gate_pkg::*;
#(
   parameter int DATA_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [DATA_SIZE-1:0] DATA_IN,
   output logic                 READY,
   output logic [DATA_SIZE-1:0] DATA_OUT
);

   localparam int FRAC = DATA_SIZE / 2;

   // Fixed-point breakpoints and offsets of the four-segment approximation
   localparam logic [DATA_SIZE-1:0] K_ONE  = DATA_SIZE'(1) << FRAC;
   localparam logic [DATA_SIZE-1:0] K_HALF = DATA_SIZE'(1) << (FRAC - 1);
   localparam logic [DATA_SIZE-1:0] K_SAT  = DATA_SIZE'(5) << FRAC;
   localparam logic [DATA_SIZE-1:0] K_HI   = DATA_SIZE'(19) << (FRAC - 3);
   localparam logic [DATA_SIZE-1:0] C_HI   = DATA_SIZE'(27) << (FRAC - 5);
   localparam logic [DATA_SIZE-1:0] C_MID  = DATA_SIZE'(5) << (FRAC - 3);

   logic                 sign_q, sign_d;
   logic [DATA_SIZE-1:0] mag_q, mag_d;
   logic                 valid_q, valid_d;
   logic                 ready_q, ready_d;
   logic [DATA_SIZE-1:0] data_out_q, data_out_d;
   logic [DATA_SIZE-1:0] y_c;

   // Stage 1 folds the input to sign/magnitude; stage 2 evaluates the segment and mirrors negatives
   always_comb begin
      sign_d  = DATA_IN[DATA_SIZE-1];
      mag_d   = sign_d ? (~DATA_IN + DATA_SIZE'(1)) : DATA_IN;
      // The most negative input has no positive twin; it lies deep in saturation anyway
      if (mag_d[DATA_SIZE-1]) begin
         mag_d = K_SAT;
      end
      valid_d = START;

      y_c = K_HALF + (mag_q >> 2);
      if (mag_q >= K_SAT) begin
         y_c = K_ONE;
      end else if (mag_q >= K_HI) begin
         y_c = C_HI + (mag_q >> 5);
      end else if (mag_q >= K_ONE) begin
         y_c = C_MID + (mag_q >> 3);
      end

      ready_d    = valid_q;
      data_out_d = data_out_q;
      if (valid_q) begin
         data_out_d = sign_q ? (K_ONE - y_c) : y_c;
      end
   end

   // Pipeline registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sign_q     <= 1'b0;
         mag_q      <= DATA_SIZE'(ZERO_DATA);
         valid_q    <= 1'b0;
         ready_q    <= 1'b0;
         data_out_q <= DATA_SIZE'(ZERO_DATA);
      end else begin
         sign_q     <= sign_d;
         mag_q      <= mag_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
         data_out_q <= data_out_d;
      end
   end

   assign READY    = ready_q;
   assign DATA_OUT = data_out_q;

endmodule

// File: rtl/accelerator_vector_write_gate.sv
// rtl/accelerator_vector_write_gate.sv - serial write gate over W heads sharing one logistic unit
module accelerator_vector_write_gate
   import accelerator_vector_write_gate_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
   input  logic                    GW_IN_ENABLE,
   output logic                    GW_ENABLE,
   input  logic [DATA_SIZE-1:0]    GW_IN,
   output logic                    GW_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]    GW_OUT
);

   state_t                  state_q, state_d;
   logic [CONTROL_SIZE-1:0] index_q, index_d;
   logic [CONTROL_SIZE-1:0] size_q, size_d;
   logic [DATA_SIZE-1:0]    gw_in_q, gw_in_d;
   logic                    log_start_q, log_start_d;
   logic                    gw_enable_q, gw_enable_d;
   logic                    gw_out_enable_q, gw_out_enable_d;
   logic [DATA_SIZE-1:0]    gw_out_q, gw_out_d;
   logic                    ready_q, ready_d;

   logic                    log_ready;
   logic [DATA_SIZE-1:0]    log_data_out;

   accelerator_scalar_logistic_function #(
      .DATA_SIZE (DATA_SIZE)
   ) u_logistic (
      .CLK      (CLK),
      .RST      (RST),
      .START    (log_start_q),
      .DATA_IN  (gw_in_q),
      .READY    (log_ready),
      .DATA_OUT (log_data_out)
   );

   // Next-state: accept one element, run it through the logistic unit, emit, repeat W times
   always_comb begin
      state_d         = state_q;
      index_d         = index_q;
      size_d          = size_q;
      gw_in_d         = gw_in_q;
      log_start_d     = 1'b0;
      gw_enable_d     = gw_enable_q;
      gw_out_enable_d = 1'b0;
      gw_out_d        = gw_out_q;
      ready_d         = 1'b0;

      case (state_q)
         STARTER_STATE: begin
            if (START) begin
               if (SIZE_W_IN != CONTROL_SIZE'(ZERO_CONTROL)) begin
                  size_d      = SIZE_W_IN;
                  index_d     = CONTROL_SIZE'(ZERO_CONTROL);
                  gw_enable_d = 1'b1;
                  state_d     = INPUT_STATE;
               end else begin
                  ready_d = 1'b1;
               end
            end
         end
         INPUT_STATE: begin
            if (GW_IN_ENABLE) begin
               gw_in_d     = GW_IN;
               gw_enable_d = 1'b0;
               log_start_d = 1'b1;
               state_d     = ENDER_STATE;
            end
         end
         ENDER_STATE: begin
            if (log_ready) begin
               gw_out_d        = log_data_out;
               gw_out_enable_d = 1'b1;
               if (index_q == size_q - CONTROL_SIZE'(ONE_CONTROL)) begin
                  ready_d = 1'b1;
                  state_d = STARTER_STATE;
               end else begin
                  index_d     = index_q + CONTROL_SIZE'(ONE_CONTROL);
                  gw_enable_d = 1'b1;
                  state_d     = INPUT_STATE;
               end
            end
         end
         default: begin
            state_d     = STARTER_STATE;
            gw_enable_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset abandons any vector in flight
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q         <= STARTER_STATE;
         index_q         <= CONTROL_SIZE'(ZERO_CONTROL);
         size_q          <= CONTROL_SIZE'(ZERO_CONTROL);
         gw_in_q         <= DATA_SIZE'(ZERO_DATA);
         log_start_q     <= 1'b0;
         gw_enable_q     <= 1'b0;
         gw_out_enable_q <= 1'b0;
         gw_out_q        <= DATA_SIZE'(ZERO_DATA);
         ready_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         index_q         <= index_d;
         size_q          <= size_d;
         gw_in_q         <= gw_in_d;
         log_start_q     <= log_start_d;
         gw_enable_q     <= gw_enable_d;
         gw_out_enable_q <= gw_out_enable_d;
         gw_out_q        <= gw_out_d;
         ready_q         <= ready_d;
      end
   end

   assign READY         = ready_q;
   assign GW_ENABLE     = gw_enable_q;
   assign GW_OUT_ENABLE = gw_out_enable_q;
   assign GW_OUT        = gw_out_q;

endmodule

// File: tb/tb_accelerator_vector_write_gate.sv
// tb/tb_accelerator_vector_write_gate.sv - randomized self-checking bench for the vector write gate
module tb_accelerator_vector_write_gate;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        START = 1'b0;
   logic        READY;
   logic [63:0] SIZE_W_IN = '0;
   logic        GW_IN_ENABLE = 1'b0;
   logic        GW_ENABLE;
   logic [63:0] GW_IN = '0;
   logic        GW_OUT_ENABLE;
   logic [63:0] GW_OUT;

   accelerator_vector_write_gate #(
      .DATA_SIZE    (64),
      .CONTROL_SIZE (64)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .START         (START),
      .READY         (READY),
      .SIZE_W_IN     (SIZE_W_IN),
      .GW_IN_ENABLE  (GW_IN_ENABLE),
      .GW_ENABLE     (GW_ENABLE),
      .GW_IN         (GW_IN),
      .GW_OUT_ENABLE (GW_OUT_ENABLE),
      .GW_OUT        (GW_OUT)
   );

   always #5 CLK = ~CLK;

   localparam real SCALE = 4294967296.0;
   localparam int  LATENCY = 3;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_oe = 0;
   int          n_ready = 0;
   logic [63:0] got[$];

   // Reference model state: what the outputs must be in the current cycle
   bit  m_busy = 0;
   bit  m_en = 0;
   bit  m_oe = 0;
   bit  m_rdy = 0;
   int  m_rem = 0;
   int  m_cnt = 0;
   real m_out = 0.0;
   real m_pend = 0.0;

   // Piecewise-linear logistic in real arithmetic, result in output LSBs
   function automatic real plan(input logic [63:0] x);
      real v, a, y;
      v = real'($signed(x)) / SCALE;
      a = (v < 0.0) ? -v : v;
      if (a >= 5.0)        y = 1.0;
      else if (a >= 2.375) y = 0.03125 * a + 0.84375;
      else if (a >= 1.0)   y = 0.125 * a + 0.625;
      else                 y = 0.25 * a + 0.5;
      if (v < 0.0) y = 1.0 - y;
      return y * SCALE;
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle, then advance the model with the inputs about to be sampled
   always @(negedge CLK) begin
      real diff;
      check_bit("gw_enable", GW_ENABLE, m_en);
      check_bit("gw_out_enable", GW_OUT_ENABLE, m_oe);
      check_bit("ready", READY, m_rdy);
      diff = real'($signed(GW_OUT)) - m_out;
      n_cmp++;
      if ($isunknown(GW_OUT) || diff > 1.0 || diff < -1.0) begin
         n_bad++;
         $display("FAIL gw_out: got %h expected %f LSB at %0t", GW_OUT, m_out, $time);
      end
      if (GW_OUT_ENABLE === 1'b1) begin
         n_oe++;
         got.push_back(GW_OUT);
      end
      if (READY === 1'b1) n_ready++;

      m_oe  = 0;
      m_rdy = 0;
      if (!RST) begin
         m_busy = 0;
         m_en   = 0;
         m_cnt  = 0;
         m_out  = 0.0;
      end else if (!m_busy) begin
         if (START) begin
            if (SIZE_W_IN != 64'd0) begin
               m_busy = 1;
               m_rem  = int'(SIZE_W_IN);
               m_en   = 1;
            end else begin
               m_rdy = 1;
            end
         end
      end else if (m_en) begin
         if (GW_IN_ENABLE) begin
            m_en   = 0;
            m_cnt  = LATENCY;
            m_pend = plan(GW_IN);
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_oe  = 1;
            m_out = m_pend;
            m_rem--;
            if (m_rem == 0) begin
               m_rdy  = 1;
               m_busy = 0;
            end else begin
               m_en = 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] rnd_data();
      logic [63:0] r;
      r = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) return r;
      return 64'($signed(r) >>> 28);
   endfunction

   task automatic wait_en(output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (GW_ENABLE === 1'b1) begin
            ok = 1;
            return;
         end
         GW_IN_ENABLE = 1'($urandom_range(0, 1));
         GW_IN        = rnd_data();
         step();
         GW_IN_ENABLE = 1'b0;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_gw_enable: got timeout expected GW_ENABLE within 200 cycles at %0t", $time);
   endtask

   task automatic wait_ready(input int target);
      for (int i = 0; i < 200; i++) begin
         if (n_ready >= target) return;
         step();
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: got %0d pulses expected %0d within 200 cycles", n_ready, target);
   endtask

   task automatic start_vec(input int w, input bit with_in_en);
      START        = 1'b1;
      SIZE_W_IN    = 64'(w);
      GW_IN_ENABLE = with_in_en;
      GW_IN        = rnd_data();
      step();
      START        = 1'b0;
      GW_IN_ENABLE = 1'b0;
      SIZE_W_IN    = {$urandom, $urandom};
   endtask

   task automatic feed(input logic [63:0] v, input int delay, input bit mid_start);
      bit ok;
      wait_en(ok);
      if (!ok) return;
      for (int i = 0; i < delay; i++) begin
         GW_IN_ENABLE = 1'b0;
         GW_IN        = rnd_data();
         START        = (mid_start && i == 2);
         SIZE_W_IN    = 64'd7;
         step();
      end
      START        = 1'b0;
      GW_IN        = v;
      GW_IN_ENABLE = 1'b1;
      step();
      GW_IN_ENABLE = 1'b0;
      GW_IN        = rnd_data();
   endtask

   initial begin
      int r0, o0, w;
      logic [63:0] vals[4];

      // Reset held with START asserted
      RST       = 1'b0;
      START     = 1'b1;
      SIZE_W_IN = 64'd3;
      repeat (3) step();
      check_bit("rst_gw_enable", GW_ENABLE, 1'b0);
      check_bit("rst_ready", READY, 1'b0);
      check_bit("rst_gw_out_enable", GW_OUT_ENABLE, 1'b0);
      check64("rst_gw_out", GW_OUT, 64'h0);
      START = 1'b0;
      RST   = 1'b1;
      step();
      check_bit("post_rst_gw_enable", GW_ENABLE, 1'b0);
      check_bit("post_rst_ready", READY, 1'b0);

      // W=1, input 0 gives exactly one half
      got.delete();
      r0 = n_ready;
      start_vec(1, 0);
      feed(64'h0, 0, 0);
      wait_ready(r0 + 1);
      step();
      check_int("w1_count", got.size(), 1);
      if (got.size() == 1) check64("w1_half", got[0], 64'h0000_0000_8000_0000);
      check_int("w1_ready", n_ready - r0, 1);

      // W=4 with START and GW_IN_ENABLE coinciding on the start cycle
      got.delete();
      r0 = n_ready;
      vals[0] = 64'h0;
      vals[1] = 64'h0000_0004_0000_0000;
      vals[2] = 64'hFFFF_FFFC_0000_0000;
      vals[3] = 64'h0000_0010_0000_0000;
      start_vec(4, 1);
      for (int i = 0; i < 4; i++) feed(vals[i], 0, 0);
      wait_ready(r0 + 1);
      step();
      check_int("w4_count", got.size(), 4);
      if (got.size() == 4) begin
         check64("w4_plus4", got[1], 64'h0000_0000_F800_0000);
         check64("w4_minus4", got[2], 64'h0000_0000_0800_0000);
         n_cmp++;
         if (!(got[3] > 64'h0000_0000_FFBE_76C8)) begin
            n_bad++;
            $display("FAIL w4_last: got %h expected above 0.999", got[3]);
         end
      end
      check_int("w4_ready", n_ready - r0, 1);

      // W=3 with stalls and a stray START mid-vector
      got.delete();
      r0 = n_ready;
      start_vec(3, 0);
      for (int i = 0; i < 3; i++) feed(rnd_data(), 5, i == 1);
      wait_ready(r0 + 1);
      repeat (12) step();
      check_int("w3_count", got.size(), 3);
      check_int("w3_ready", n_ready - r0, 1);

      // Zero-length vector
      r0 = n_ready;
      o0 = n_oe;
      start_vec(0, 0);
      step();
      step();
      check_int("w0_ready", n_ready - r0, 1);
      check_int("w0_outputs", n_oe - o0, 0);

      // Reset while element 2 of 5 is in the logistic unit
      r0 = n_ready;
      o0 = n_oe;
      start_vec(5, 0);
      for (int i = 0; i < 3; i++) feed(rnd_data(), 0, 0);
      RST = 1'b0;
      step();
      step();
      RST = 1'b1;
      repeat (8) step();
      check_int("abandon_outputs", n_oe - o0, 2);
      check_int("abandon_ready", n_ready - r0, 0);
      got.delete();
      start_vec(2, 0);
      for (int i = 0; i < 2; i++) feed(rnd_data(), 1, 0);
      wait_ready(r0 + 1);
      step();
      check_int("after_rst_count", got.size(), 2);

      // Randomized vectors, including saturating and extreme inputs
      for (int v = 0; v < 25; v++) begin
         got.delete();
         r0 = n_ready;
         w  = $urandom_range(1, 6);
         start_vec(w, 1'($urandom_range(0, 1)));
         for (int i = 0; i < w; i++) begin
            if (v == 3 && i == 0) feed(64'h8000_0000_0000_0000, 0, 0);
            else feed(rnd_data(), $urandom_range(0, 3), $urandom_range(0, 4) == 0);
         end
         wait_ready(r0 + 1);
         repeat ($urandom_range(1, 4)) step();
         check_int("rand_count", got.size(), w);
      end

      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
